// File: rtl/ring_arb_pkg.sv
// Shared types, defaults and pure helpers for the round-robin ring arbiter.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N        = 3;
    localparam int DEF_MAX_HOLD = 4;
    localparam int MAXN         = 32;

    // First set bit of req at or after the ptr position, wrapping modulo n.
    function automatic logic [MAXN-1:0] rr_pick(
        input logic [MAXN-1:0] req,
        input logic [MAXN-1:0] ptr,
        input int              n
    );
        logic [MAXN-1:0] res;
        logic            found;
        int              p;
        int              idx;
        res   = '0;
        found = 1'b0;
        p     = 0;
        idx   = 0;
        for (int i = 0; i < MAXN; i++) begin
            if ((i < n) && ptr[i]) begin
                p = i;
            end
        end
        for (int k = 0; k < MAXN; k++) begin
            if ((k < n) && !found) begin
                idx = (p + k) % n;
                if (req[idx]) begin
                    res[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot2bin(input logic [MAXN-1:0] v);
        logic [7:0] bin;
        bin = 8'd0;
        for (int i = 0; i < MAXN; i++) begin
            if (v[i]) begin
                bin = bin | 8'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/ring_arb_chk.sv
// Invariant checker for the ring arbiter outputs; simulation-only assertions.
module ring_arb_chk #(
    parameter int N = 3
) (
    input logic         clk,
    input logic         rst,
    input logic [N-1:0] req,
    input logic [N-1:0] gnt,
    input logic         busy
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    a_busy_matches: assert property (@(posedge clk) disable iff (rst) busy == (|gnt));

    // A newly appearing grant must belong to a requester seen on the granting edge.
    a_gnt_requested: assert property (@(posedge clk) disable iff (rst)
        ((gnt != '0) && (gnt != $past(gnt))) |-> ((gnt & $past(req)) != '0));

endmodule

// File: rtl/ring_ptr.sv
// One-hot rotate-left priority pointer; load takes precedence over rotate.
module ring_ptr #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q
);

    logic [N-1:0] q_r;

    // Pointer register: reset to bit 0, then load or rotate.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= N'(1);
        end else if (load) begin
            q_r <= load_val;
        end else if (en) begin
            q_r <= {q_r[N-2:0], q_r[N-1]};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held while requested,
// optional hold-time limit, rotating one-hot priority pointer.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           expired,
    output logic [N-1:0]   ptr
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b1}};
    localparam logic [HW-1:0] HOLD_SAT  = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : {HW{1'b1}};

    arb_state_e     state_r;
    arb_state_e     state_nx_s;
    logic [N-1:0]   gnt_r;
    logic [N-1:0]   gnt_nx_s;
    logic [IDW-1:0] gnt_id_r;
    logic           busy_r;
    logic           expired_r;
    logic           expired_nx_s;
    logic [HW-1:0]  hold_r;
    logic [HW-1:0]  hold_nx_s;
    logic [N-1:0]   ptr_q_s;
    logic           ptr_load_s;
    logic [N-1:0]   ptr_load_val_s;
    logic [N-1:0]   cand_s;
    logic           owner_hit_s;
    logic           force_s;

    ring_ptr #(.N(N)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .en       (1'b0),
        .load     (ptr_load_s),
        .load_val (ptr_load_val_s),
        .q        (ptr_q_s)
    );

    // Next-state, next-grant and pointer-load decision.
    always_comb begin
        state_nx_s     = state_r;
        gnt_nx_s       = gnt_r;
        expired_nx_s   = 1'b0;
        hold_nx_s      = hold_r;
        ptr_load_s     = 1'b0;
        ptr_load_val_s = ptr_q_s;
        cand_s         = req & ~gnt_r;
        owner_hit_s    = |(req & gnt_r);
        force_s        = (MAX_HOLD > 0) && owner_hit_s && (hold_r == HOLD_LAST);
        case (state_r)
            IDLE: begin
                hold_nx_s = '0;
                if (|req) begin
                    gnt_nx_s   = N'(rr_pick(MAXN'(req), MAXN'(ptr_q_s), N));
                    state_nx_s = GRANT;
                end else begin
                    gnt_nx_s   = '0;
                    state_nx_s = IDLE;
                end
            end
            GRANT: begin
                if (!owner_hit_s || force_s) begin
                    // Release: priority moves past the owner, owner is excluded this edge.
                    ptr_load_s     = 1'b1;
                    ptr_load_val_s = {gnt_r[N-2:0], gnt_r[N-1]};
                    gnt_nx_s       = N'(rr_pick(MAXN'(cand_s), MAXN'(ptr_load_val_s), N));
                    state_nx_s     = (|cand_s) ? GRANT : IDLE;
                    hold_nx_s      = '0;
                    expired_nx_s   = force_s;
                end else begin
                    hold_nx_s = (hold_r == HOLD_SAT) ? hold_r : hold_r + HW'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                gnt_nx_s   = '0;
                hold_nx_s  = '0;
            end
        endcase
    end

    // State, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt_r     <= '0;
            gnt_id_r  <= '0;
            busy_r    <= 1'b0;
            expired_r <= 1'b0;
            hold_r    <= '0;
        end else begin
            state_r   <= state_nx_s;
            gnt_r     <= gnt_nx_s;
            gnt_id_r  <= IDW'(onehot2bin(MAXN'(gnt_nx_s)));
            busy_r    <= |gnt_nx_s;
            expired_r <= expired_nx_s;
            hold_r    <= hold_nx_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign expired = expired_r;
    assign ptr     = ptr_q_s;

    ring_arb_chk #(.N(N)) u_chk (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt_r),
        .busy (busy_r)
    );

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench: directed plan steps plus random traffic, all checked
// against an owner/pointer-index reference model.
module tb_ring_rr_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = $clog2(N);

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           expired;
    logic [N-1:0]   ptr;

    int tests;
    int fails;

    // Reference model: owner index (-1 = none), pointer index, cycles held.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_exp;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .expired (expired),
        .ptr     (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [N-1:0] r);
        bit frc;
        logic [N-1:0] c;
        if (r_rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_exp = 1'b0;
        end else if (m_owner < 0) begin
            m_exp   = 1'b0;
            m_owner = pick(r, m_ptr);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else begin
            frc = (MAX_HOLD > 0) && r[m_owner] && (m_held >= MAX_HOLD);
            if (!r[m_owner] || frc) begin
                c = r;
                c[m_owner] = 1'b0;
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(c, m_ptr);
                m_held  = (m_owner >= 0) ? 1 : 0;
                m_exp   = frc;
            end else begin
                m_held++;
                m_exp = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, compare 1 later.
    task automatic step(input logic r_rst, input logic [N-1:0] r);
        logic [N-1:0] eg;
        @(negedge clk);
        rst = r_rst;
        req = r;
        @(posedge clk);
        model_edge(r_rst, r);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("model_gnt", int'(gnt), int'(eg));
        chk("model_gnt_id", int'(gnt_id), (m_owner >= 0) ? m_owner : 0);
        chk("model_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        chk("model_expired", int'(expired), int'(m_exp));
        chk("model_ptr", int'(ptr), 1 << m_ptr);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req = '0;
        m_owner = -1; m_ptr = 0; m_held = 0; m_exp = 1'b0;

        // Reset with all requesting, then first grant.
        step(1'b1, 3'b111);
        step(1'b1, 3'b111);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_ptr", int'(ptr), 1);
        chk("rst_busy", int'(busy), 0);
        step(1'b0, 3'b111);
        chk("first_gnt", int'(gnt), 1);

        // Fairness: each owner drops its bit after two granted cycles.
        step(1'b0, 3'b111);
        step(1'b0, 3'b110);
        chk("fair_gnt1", int'(gnt), 2);
        chk("fair_ptr1", int'(ptr), 2);
        step(1'b0, 3'b111);
        step(1'b0, 3'b101);
        chk("fair_gnt2", int'(gnt), 4);
        chk("fair_ptr2", int'(ptr), 4);
        step(1'b0, 3'b111);
        step(1'b0, 3'b011);
        chk("fair_gnt3", int'(gnt), 1);
        chk("fair_ptr3", int'(ptr), 1);

        // Single requester.
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);
        chk("single_gnt", int'(gnt), 2);
        chk("single_id", int'(gnt_id), 1);
        step(1'b0, 3'b010);
        step(1'b0, 3'b010);
        step(1'b0, 3'b000);
        chk("single_rel_gnt", int'(gnt), 0);
        chk("single_rel_ptr", int'(ptr), 4);

        // Timeout ping-pong between two constant requesters.
        step(1'b1, 3'b011);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b011);
            chk("to_hold0", int'(gnt), 1);
        end
        step(1'b0, 3'b011);
        chk("to_gnt1", int'(gnt), 2);
        chk("to_exp1", int'(expired), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b011);
            chk("to_hold1", int'(gnt), 2);
            chk("to_exp_low", int'(expired), 0);
        end
        step(1'b0, 3'b011);
        chk("to_gnt2", int'(gnt), 1);
        chk("to_exp2", int'(expired), 1);

        // Timeout with no other candidate: one idle cycle, then re-win.
        step(1'b1, 3'b001);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b001);
        step(1'b0, 3'b001);
        chk("solo_to_gnt", int'(gnt), 0);
        chk("solo_to_exp", int'(expired), 1);
        step(1'b0, 3'b001);
        chk("solo_rewin", int'(gnt), 1);

        // Reset in the middle of a grant.
        step(1'b1, 3'b000);
        step(1'b0, 3'b100);
        step(1'b0, 3'b100);
        step(1'b0, 3'b100);
        chk("mid_pre_gnt", int'(gnt), 4);
        step(1'b1, 3'b100);
        chk("mid_gnt", int'(gnt), 0);
        chk("mid_ptr", int'(ptr), 1);
        chk("mid_exp", int'(expired), 0);

        // Simultaneous release and new request: bubble-free handoff.
        step(1'b0, 3'b001);
        chk("sim_pre", int'(gnt), 1);
        step(1'b0, 3'b100);
        chk("sim_gnt", int'(gnt), 4);
        chk("sim_ptr", int'(ptr), 2);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
